// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, driver states and flag indices for the ALU command driver
//
// Purpose: common types and constants for the ALU command-side master.
//   alu_op_e    : the ten ALUControl codes understood by the attached ALU
//   OP_LAST     : highest legal ALUControl code
//   OP_DEFAULT  : code substituted for an unsupported request (suma)
//   drv_state_e : driver FSM states
//   FLG_*       : bit positions inside res_flags {neg, zero, carry}
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_NOT = 4'b0010,
        OP_XOR = 4'b0011,
        OP_ADD = 4'b0100,
        OP_SUB = 4'b0101,
        OP_SLL = 4'b0110,
        OP_SRL = 4'b0111,
        OP_SLA = 4'b1000,
        OP_SRA = 4'b1001
    } alu_op_e;

    localparam logic [3:0] OP_LAST    = 4'b1001;
    localparam logic [3:0] OP_DEFAULT = 4'b0100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } drv_state_e;

    localparam int FLG_N = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_C = 0;

endpackage

// File: rtl/alu_cmd_driver.sv
// rtl/alu_cmd_driver.sv - command-side master that issues one op to a combinational ALU and returns its result
//
// Purpose: accepts an operation over cmd_valid/cmd_ready, drives registered
// operands and opcode into an external ALU, captures Y and flags one cycle
// later, and offers them over res_valid/res_ready.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   cmd_valid/cmd_ready         request handshake
//   cmd_op, cmd_a, cmd_b        requested ALUControl code and operands
//   cmd_chain                   use last captured result as operand A
//   alu_a, alu_b, alu_ctrl      registered drive into the ALU
//   alu_y, alu_neg/zero/carry   ALU result and flags
//   res_valid/res_ready         result handshake
//   res_y, res_flags            captured result, flags {neg, zero, carry}
//   res_illegal                 request carried an unsupported opcode
//   op_count                    completed result handshakes (wrapping)
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [N-1:0]     cmd_a,
    input  logic [N-1:0]     cmd_b,
    input  logic             cmd_chain,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [N-1:0]     alu_y,
    input  logic             alu_neg,
    input  logic             alu_zero,
    input  logic             alu_carry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     res_y,
    output logic [2:0]       res_flags,
    output logic             res_illegal,
    output logic [CNT_W-1:0] op_count
);

    drv_state_e     state;
    drv_state_e     state_nxt;
    logic [N-1:0]   last_y;
    logic           illegal_q;
    logic           op_illegal;
    logic [3:0]     op_legal;
    logic           cmd_fire;
    logic           res_fire;

    // Unsupported codes run as suma so the ALU always sees a defined op;
    // the illegal bit travels with that one result only.
    assign op_illegal = (cmd_op > OP_LAST);
    assign op_legal   = op_illegal ? OP_DEFAULT : cmd_op;

    assign cmd_fire = cmd_valid & cmd_ready;
    assign res_fire = res_valid & res_ready;

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                // ALU settles during this full cycle; capture at its end.
                state_nxt = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                // Returning to IDLE (not straight to EXEC) keeps cmd_ready
                // low during the result handshake cycle.
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctrl    <= '0;
            res_y       <= '0;
            res_flags   <= '0;
            res_illegal <= 1'b0;
            op_count    <= '0;
            last_y      <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state <= state_nxt;

            if (cmd_fire) begin
                alu_a     <= cmd_chain ? last_y : cmd_a;
                alu_b     <= cmd_b;
                alu_ctrl  <= op_legal;
                illegal_q <= op_illegal;
            end

            if (state == EXEC) begin
                res_y            <= alu_y;
                res_flags[FLG_N] <= alu_neg;
                res_flags[FLG_Z] <= alu_zero;
                res_flags[FLG_C] <= alu_carry;
                res_illegal      <= illegal_q;
                last_y           <= alu_y;
            end

            if (res_fire) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb/tb_alu_cmd_driver.sv - self-checking bench for alu_cmd_driver with a behavioural ALU attached
module tb_alu_cmd_driver;
    import alu_pkg::*;

    localparam int N     = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [3:0]       cmd_op = '0;
    logic [N-1:0]     cmd_a = '0;
    logic [N-1:0]     cmd_b = '0;
    logic             cmd_chain = 1'b0;
    logic [N-1:0]     alu_a;
    logic [N-1:0]     alu_b;
    logic [3:0]       alu_ctrl;
    logic [N-1:0]     alu_y;
    logic             alu_neg;
    logic             alu_zero;
    logic             alu_carry;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [N-1:0]     res_y;
    logic [2:0]       res_flags;
    logic             res_illegal;
    logic [CNT_W-1:0] op_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [N-1:0]     model_last_y;
    logic [CNT_W-1:0] model_count;

    always #5 clk = ~clk;

    alu_cmd_driver #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_y(alu_y), .alu_neg(alu_neg), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_flags(res_flags), .res_illegal(res_illegal),
        .op_count(op_count)
    );

    // ALU behaviour: returns {y, neg, zero, carry}
    function automatic logic [N+2:0] alu_fn(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0]   wide;
        logic [N-1:0] y;
        logic         n;
        logic         c;
        n = 1'b0;
        c = 1'b0;
        case (op)
            4'd0: y = a & b;
            4'd1: y = a | b;
            4'd2: y = ~a;
            4'd3: y = a ^ b;
            4'd4: begin wide = {1'b0, a} + {1'b0, b}; y = wide[N-1:0]; c = wide[N]; end
            4'd5: begin y = a - b; n = (a < b); end
            4'd6: y = a << b;
            4'd7: y = a >> b;
            4'd8: y = a << b;
            4'd9: y = $unsigned($signed(a) >>> b);
            default: y = '0;
        endcase
        return {y, n, (y == '0), c};
    endfunction

    always_comb begin
        {alu_y, alu_neg, alu_zero, alu_carry} = alu_fn(alu_ctrl, alu_a, alu_b);
    end

    // Reference: what one completed request should produce; advances model state.
    task automatic model_step(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic chain, output logic [N-1:0] e_a, output logic [3:0] e_ctrl,
                              output logic [N-1:0] e_y, output logic [2:0] e_f, output logic e_ill);
        e_ill  = (op >= 4'd10);
        e_ctrl = e_ill ? 4'd4 : op;
        e_a    = chain ? model_last_y : a;
        {e_y, e_f} = alu_fn(e_ctrl, e_a, b);
        model_last_y = e_y;
        model_count  = model_count + 1'b1;
    endtask

    // Issues one request and returns what was observed; release=0 leaves the driver in RESP.
    task automatic run_op(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic chain, input logic release_res,
                          output logic [N-1:0] o_a, output logic [N-1:0] o_b, output logic [3:0] o_ctrl,
                          output logic [N-1:0] o_y, output logic [2:0] o_f, output logic o_ill,
                          output int lat);
        int w;
        @(negedge clk);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain; cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        o_a = alu_a; o_b = alu_b; o_ctrl = alu_ctrl;
        lat = 1;
        while (!res_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!res_valid || w >= 10) lat = 99;
        o_y = res_y; o_f = res_flags; o_ill = res_illegal;
        if (release_res) begin
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        rst_n = 1'b1;
        model_last_y = '0;
        model_count = '0;
        total_cnt++;
        if ({alu_a, alu_b, alu_ctrl, res_y, res_flags, res_illegal, op_count, res_valid} !== '0)
            $display("FAIL reset_zero: got a=%h b=%h ctrl=%h y=%h f=%b ill=%b cnt=%0d rv=%b, want all 0",
                     alu_a, alu_b, alu_ctrl, res_y, res_flags, res_illegal, op_count, res_valid);
        else pass_cnt++;
        total_cnt++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        else pass_cnt++;
    endtask

    task automatic test_add();
        logic [N-1:0] oa, ob, oy; logic [3:0] oc; logic [2:0] of; logic oi; int lat;
        logic [N-1:0] ea, ey; logic [3:0] ec; logic [2:0] ef; logic ei;
        run_op(4'b0100, 4'd9, 4'd8, 1'b0, 1'b1, oa, ob, oc, oy, of, oi, lat);
        model_step(4'b0100, 4'd9, 4'd8, 1'b0, ea, ec, ey, ef, ei);
        total_cnt++;
        if (oc !== 4'b0100) $display("FAIL add_ctrl: got %b want 0100", oc); else pass_cnt++;
        total_cnt++;
        if (oy !== 4'h1 || of !== 3'b001) $display("FAIL add_result: got y=%h f=%b want y=1 f=001", oy, of); else pass_cnt++;
        total_cnt++;
        if (lat !== 2) $display("FAIL add_latency: got %0d want 2", lat); else pass_cnt++;
        total_cnt++;
        if (op_count !== 8'd1) $display("FAIL add_count: got %0d want 1", op_count); else pass_cnt++;
    endtask

    task automatic test_sub_xor();
        logic [N-1:0] oa, ob, oy; logic [3:0] oc; logic [2:0] of; logic oi; int lat;
        logic [N-1:0] ea, ey; logic [3:0] ec; logic [2:0] ef; logic ei;
        run_op(4'b0101, 4'd3, 4'd5, 1'b0, 1'b1, oa, ob, oc, oy, of, oi, lat);
        model_step(4'b0101, 4'd3, 4'd5, 1'b0, ea, ec, ey, ef, ei);
        total_cnt++;
        if (oy !== 4'hE || of[2] !== 1'b1) $display("FAIL sub_neg: got y=%h f=%b want y=e neg=1", oy, of); else pass_cnt++;
        run_op(4'b0011, 4'd5, 4'd5, 1'b0, 1'b1, oa, ob, oc, oy, of, oi, lat);
        model_step(4'b0011, 4'd5, 4'd5, 1'b0, ea, ec, ey, ef, ei);
        total_cnt++;
        if (oy !== 4'h0 || of !== 3'b010) $display("FAIL xor_zero: got y=%h f=%b want y=0 f=010", oy, of); else pass_cnt++;
    endtask

    task automatic test_chain();
        logic [N-1:0] oa, ob, oy; logic [3:0] oc; logic [2:0] of; logic oi; int lat;
        logic [N-1:0] ea, ey; logic [3:0] ec; logic [2:0] ef; logic ei;
        run_op(4'b0100, 4'd3, 4'd4, 1'b0, 1'b1, oa, ob, oc, oy, of, oi, lat);
        model_step(4'b0100, 4'd3, 4'd4, 1'b0, ea, ec, ey, ef, ei);
        run_op(4'b0100, 4'hF, 4'd2, 1'b1, 1'b1, oa, ob, oc, oy, of, oi, lat);
        model_step(4'b0100, 4'hF, 4'd2, 1'b1, ea, ec, ey, ef, ei);
        total_cnt++;
        if (oa !== 4'd7 || oy !== 4'd9) $display("FAIL chain: got alu_a=%h y=%h want alu_a=7 y=9", oa, oy); else pass_cnt++;
    endtask

    task automatic test_illegal();
        logic [N-1:0] oa, ob, oy; logic [3:0] oc; logic [2:0] of; logic oi; int lat;
        logic [N-1:0] ea, ey; logic [3:0] ec; logic [2:0] ef; logic ei;
        run_op(4'b1100, 4'd2, 4'd3, 1'b0, 1'b1, oa, ob, oc, oy, of, oi, lat);
        model_step(4'b1100, 4'd2, 4'd3, 1'b0, ea, ec, ey, ef, ei);
        total_cnt++;
        if (oc !== 4'b0100 || oy !== 4'd5 || oi !== 1'b1)
            $display("FAIL illegal_op: got ctrl=%b y=%h ill=%b want ctrl=0100 y=5 ill=1", oc, oy, oi);
        else pass_cnt++;
        run_op(4'b0000, 4'd6, 4'd3, 1'b0, 1'b1, oa, ob, oc, oy, of, oi, lat);
        model_step(4'b0000, 4'd6, 4'd3, 1'b0, ea, ec, ey, ef, ei);
        total_cnt++;
        if (oi !== 1'b0 || oy !== 4'd2) $display("FAIL illegal_clear: got ill=%b y=%h want ill=0 y=2", oi, oy); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [N-1:0] oa, ob, oy; logic [3:0] oc; logic [2:0] of; logic oi; int lat;
        logic [N-1:0] ea, ey; logic [3:0] ec; logic [2:0] ef; logic ei;
        logic [CNT_W-1:0] cnt0;
        int bad;
        cnt0 = model_count;
        run_op(4'b0101, 4'd1, 4'd7, 1'b0, 1'b0, oa, ob, oc, oy, of, oi, lat);
        model_step(4'b0101, 4'd1, 4'd7, 1'b0, ea, ec, ey, ef, ei);
        cmd_valid = 1'b1;
        cmd_op = 4'b0001; cmd_a = 4'hA; cmd_b = 4'h5; cmd_chain = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (res_y !== ey || res_flags !== ef || cmd_ready !== 1'b0 || res_valid !== 1'b1 || op_count !== cnt0) bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL hold_stable: %0d bad cycles, y=%h f=%b crdy=%b cnt=%0d want y=%h f=%b crdy=0 cnt=%0d",
                               bad, res_y, res_flags, cmd_ready, op_count, ey, ef, cnt0);
        else pass_cnt++;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        total_cnt++;
        if (op_count !== model_count || cmd_ready !== 1'b1)
            $display("FAIL release: got cnt=%0d crdy=%b want cnt=%0d crdy=1", op_count, cmd_ready, model_count);
        else pass_cnt++;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset_exec();
        int bad;
        @(negedge clk);
        cmd_op = 4'b0100; cmd_a = 4'd1; cmd_b = 4'd1; cmd_chain = 1'b0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_last_y = '0;
        model_count = '0;
        total_cnt++;
        if ({alu_a, alu_b, alu_ctrl, res_y, res_flags, res_illegal, op_count} !== '0 || cmd_ready !== 1'b1)
            $display("FAIL reset_exec: got a=%h b=%h ctrl=%h y=%h f=%b cnt=%0d crdy=%b want zeros crdy=1",
                     alu_a, alu_b, alu_ctrl, res_y, res_flags, op_count, cmd_ready);
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (res_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        total_cnt++;
        if (bad != 0) $display("FAIL reset_exec_no_result: res_valid high %0d cycles want 0", bad); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [N-1:0] oa, ob, oy; logic [3:0] oc; logic [2:0] of; logic oi; int lat;
        logic [N-1:0] ea, ey; logic [3:0] ec; logic [2:0] ef; logic ei;
        logic [3:0] op; logic [N-1:0] a, b; logic ch;
        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = N'($urandom);
            b  = N'($urandom);
            ch = 1'($urandom_range(0, 1));
            run_op(op, a, b, ch, 1'b1, oa, ob, oc, oy, of, oi, lat);
            model_step(op, a, b, ch, ea, ec, ey, ef, ei);
            total_cnt++;
            if (oa !== ea || ob !== b || oc !== ec || oy !== ey || of !== ef || oi !== ei || lat !== 2 || op_count !== model_count)
                $display("FAIL rand_%0d: op=%h got a=%h b=%h ctrl=%h y=%h f=%b ill=%b lat=%0d cnt=%0d want a=%h b=%h ctrl=%h y=%h f=%b ill=%b lat=2 cnt=%0d",
                         i, op, oa, ob, oc, oy, of, oi, lat, op_count, ea, b, ec, ey, ef, ei, model_count);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_xor();
        test_chain();
        test_illegal();
        test_backpressure();
        test_reset_exec();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
